// File: rtl/mbscore_cpu_core.sv
// -----------------------------------------------------------------------------
// mbscore_cpu_core
//   Single-cycle MIPS-style integer execute core: 32-entry register file,
//   instruction decoder and ALU. One instruction is executed per clock; its
//   result is registered onto alu_result and written back to the register
//   file on the same rising edge. There are no loads, stores or branches.
//
// Ports
//   clk        in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset (clears registers and output)
//   inst       in   MIPS32-encoded instruction executed this cycle
//   alu_result out  registered ALU result of the instruction from the last edge
//
// Build option
//   MBS_OVF_TRAP_EN : when defined, signed overflow on add/sub/addi suppresses
//                     the register write (alu_result still shows the wrapped
//                     value). When undefined, add/sub/addi always write back.
// -----------------------------------------------------------------------------
module mbscore_cpu_core #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] alu_result
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  // Instruction fields
  logic [5:0]                op_s;
  logic [REG_ADDR_WIDTH-1:0] rs_s;
  logic [REG_ADDR_WIDTH-1:0] rt_s;
  logic [REG_ADDR_WIDTH-1:0] rd_s;
  logic [4:0]                shamt_s;
  logic [5:0]                funct_s;
  logic [15:0]               imm_s;

  // Operands and intermediate results
  logic [DATA_WIDTH-1:0] rs_val_s;
  logic [DATA_WIDTH-1:0] rt_val_s;
  logic [DATA_WIDTH-1:0] imm_sext_s;
  logic [DATA_WIDTH-1:0] imm_zext_s;
  logic [DATA_WIDTH-1:0] sum_s;
  logic [DATA_WIDTH-1:0] diff_s;
  logic [DATA_WIDTH-1:0] sum_imm_s;

  // Next-state values
  logic [DATA_WIDTH-1:0]     alu_result_d;
  logic                      supported_d;
  logic                      ovf_d;
  logic                      wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_d;

  // State
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] alu_result_q;

  assign op_s    = inst[31:26];
  assign rs_s    = inst[25:21];
  assign rt_s    = inst[20:16];
  assign rd_s    = inst[15:11];
  assign shamt_s = inst[10:6];
  assign funct_s = inst[5:0];
  assign imm_s   = inst[15:0];

  assign alu_result = alu_result_q;

  // Operand fetch, immediate extension and shared adders
  always_comb begin
    // $0 is hard-wired to zero regardless of storage contents
    rs_val_s   = (rs_s == {REG_ADDR_WIDTH{1'b0}}) ? {DATA_WIDTH{1'b0}} : regs_q[rs_s];
    rt_val_s   = (rt_s == {REG_ADDR_WIDTH{1'b0}}) ? {DATA_WIDTH{1'b0}} : regs_q[rt_s];
    imm_sext_s = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
    imm_zext_s = {{(DATA_WIDTH-16){1'b0}}, imm_s};
    sum_s      = rs_val_s + rt_val_s;
    diff_s     = rs_val_s - rt_val_s;
    sum_imm_s  = rs_val_s + imm_sext_s;
  end

  // Decode and ALU: result, write enable and destination for this instruction.
  // An unknown opcode/funct matches no case item and falls to the default arm,
  // so undriven instructions never write the register file.
  always_comb begin
    alu_result_d = {DATA_WIDTH{1'b0}};
    supported_d  = 1'b0;
    ovf_d        = 1'b0;
    wr_addr_d    = rd_s;

    case (op_s)
      6'h00: begin
        wr_addr_d = rd_s;
        case (funct_s)
          6'h20: begin
            alu_result_d = sum_s;
            supported_d  = 1'b1;
`ifdef MBS_OVF_TRAP_EN
            // operands share a sign but the sum does not
            ovf_d = (rs_val_s[DATA_WIDTH-1] == rt_val_s[DATA_WIDTH-1]) &&
                    (sum_s[DATA_WIDTH-1] != rs_val_s[DATA_WIDTH-1]);
`else
            ovf_d = 1'b0;
`endif
          end
          6'h21: begin
            alu_result_d = sum_s;
            supported_d  = 1'b1;
          end
          6'h22: begin
            alu_result_d = diff_s;
            supported_d  = 1'b1;
`ifdef MBS_OVF_TRAP_EN
            // operands differ in sign and the difference takes rt's sign
            ovf_d = (rs_val_s[DATA_WIDTH-1] != rt_val_s[DATA_WIDTH-1]) &&
                    (diff_s[DATA_WIDTH-1] != rs_val_s[DATA_WIDTH-1]);
`else
            ovf_d = 1'b0;
`endif
          end
          6'h23: begin
            alu_result_d = diff_s;
            supported_d  = 1'b1;
          end
          6'h24: begin
            alu_result_d = rs_val_s & rt_val_s;
            supported_d  = 1'b1;
          end
          6'h25: begin
            alu_result_d = rs_val_s | rt_val_s;
            supported_d  = 1'b1;
          end
          6'h26: begin
            alu_result_d = rs_val_s ^ rt_val_s;
            supported_d  = 1'b1;
          end
          6'h27: begin
            alu_result_d = ~(rs_val_s | rt_val_s);
            supported_d  = 1'b1;
          end
          6'h2A: begin
            alu_result_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs_val_s) < $signed(rt_val_s))};
            supported_d  = 1'b1;
          end
          6'h2B: begin
            alu_result_d = {{(DATA_WIDTH-1){1'b0}}, (rs_val_s < rt_val_s)};
            supported_d  = 1'b1;
          end
          6'h00: begin
            alu_result_d = rt_val_s << shamt_s;
            supported_d  = 1'b1;
          end
          6'h02: begin
            alu_result_d = rt_val_s >> shamt_s;
            supported_d  = 1'b1;
          end
          6'h03: begin
            alu_result_d = $unsigned($signed(rt_val_s) >>> shamt_s);
            supported_d  = 1'b1;
          end
          6'h04: begin
            alu_result_d = rt_val_s << rs_val_s[4:0];
            supported_d  = 1'b1;
          end
          6'h06: begin
            alu_result_d = rt_val_s >> rs_val_s[4:0];
            supported_d  = 1'b1;
          end
          6'h07: begin
            alu_result_d = $unsigned($signed(rt_val_s) >>> rs_val_s[4:0]);
            supported_d  = 1'b1;
          end
          default: begin
            alu_result_d = {DATA_WIDTH{1'b0}};
            supported_d  = 1'b0;
          end
        endcase
      end
      6'h08: begin
        wr_addr_d    = rt_s;
        alu_result_d = sum_imm_s;
        supported_d  = 1'b1;
`ifdef MBS_OVF_TRAP_EN
        ovf_d = (rs_val_s[DATA_WIDTH-1] == imm_sext_s[DATA_WIDTH-1]) &&
                (sum_imm_s[DATA_WIDTH-1] != rs_val_s[DATA_WIDTH-1]);
`else
        ovf_d = 1'b0;
`endif
      end
      6'h09: begin
        wr_addr_d    = rt_s;
        alu_result_d = sum_imm_s;
        supported_d  = 1'b1;
      end
      6'h0A: begin
        wr_addr_d    = rt_s;
        alu_result_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs_val_s) < $signed(imm_sext_s))};
        supported_d  = 1'b1;
      end
      6'h0B: begin
        // sign-extended immediate, compared as unsigned
        wr_addr_d    = rt_s;
        alu_result_d = {{(DATA_WIDTH-1){1'b0}}, (rs_val_s < imm_sext_s)};
        supported_d  = 1'b1;
      end
      6'h0C: begin
        wr_addr_d    = rt_s;
        alu_result_d = rs_val_s & imm_zext_s;
        supported_d  = 1'b1;
      end
      6'h0D: begin
        wr_addr_d    = rt_s;
        alu_result_d = rs_val_s | imm_zext_s;
        supported_d  = 1'b1;
      end
      6'h0E: begin
        wr_addr_d    = rt_s;
        alu_result_d = rs_val_s ^ imm_zext_s;
        supported_d  = 1'b1;
      end
      6'h0F: begin
        wr_addr_d    = rt_s;
        alu_result_d = {imm_s, {(DATA_WIDTH-16){1'b0}}};
        supported_d  = 1'b1;
      end
      default: begin
        wr_addr_d    = rd_s;
        alu_result_d = {DATA_WIDTH{1'b0}};
        supported_d  = 1'b0;
      end
    endcase

    wr_en_d = supported_d && !ovf_d && (wr_addr_d != {REG_ADDR_WIDTH{1'b0}});
  end

  // Register file write-back and result register; reset clears all state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      alu_result_q <= {DATA_WIDTH{1'b0}};
    end else begin
      alu_result_q <= alu_result_d;
      if (wr_en_d) begin
        regs_q[wr_addr_d] <= alu_result_d;
      end
    end
  end

endmodule

// File: tb/tb_mbscore_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_mbscore_cpu_core
//   Self-checking bench for mbscore_cpu_core. A behavioural model (plain
//   64-bit arithmetic over an array of register values) predicts each result;
//   a negedge compare process checks alu_result every cycle, and a directed
//   sequence pins hand-computed literal results. Randomised instructions
//   follow, then a mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_mbscore_cpu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] alu_result;

  int tests_run;
  int tests_failed;

  logic [31:0] m_regs [32];
  logic [31:0] exp_alu;
  bit          check_en;

  mbscore_cpu_core #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .alu_result(alu_result)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict result, write enable and destination from the instruction rules
  function automatic void model_exec(input logic [31:0] i, output logic [31:0] res,
                                     output bit we, output logic [4:0] dst);
    logic [31:0] a, b, se, ze;
    longint      sa, sb, sse, wide;
    bit          ovf;
    int          sh;
    a    = m_regs[i[25:21]];
    b    = m_regs[i[20:16]];
    se   = {{16{i[15]}}, i[15:0]};
    ze   = {16'h0000, i[15:0]};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sse  = longint'($signed(se));
    sh   = int'(i[10:6]);
    res  = 32'h0;
    we   = 1'b1;
    ovf  = 1'b0;
    wide = 64'sd0;
    if (i[31:26] == 6'h00) begin
      dst = i[15:11];
      case (i[5:0])
        6'h20: begin wide = sa + sb; res = 32'(wide); ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
        6'h21: res = 32'(sa + sb);
        6'h22: begin wide = sa - sb; res = 32'(wide); ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
        6'h23: res = 32'(sa - sb);
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = 32'(sb >>> sh);
        6'h04: res = b << a[4:0];
        6'h06: res = b >> a[4:0];
        6'h07: res = 32'(sb >>> a[4:0]);
        default: begin res = 32'h0; we = 1'b0; end
      endcase
    end else begin
      dst = i[20:16];
      case (i[31:26])
        6'h08: begin wide = sa + sse; res = 32'(wide); ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
        6'h09: res = 32'(sa + sse);
        6'h0A: res = (sa < sse) ? 32'd1 : 32'd0;
        6'h0B: res = (a < se) ? 32'd1 : 32'd0;
        6'h0C: res = a & ze;
        6'h0D: res = a | ze;
        6'h0E: res = a ^ ze;
        6'h0F: res = {i[15:0], 16'h0000};
        default: begin res = 32'h0; we = 1'b0; end
      endcase
    end
`ifdef MBS_OVF_TRAP_EN
    if (ovf) we = 1'b0;
`endif
    if (dst == 5'd0) we = 1'b0;
  endfunction

  // Cycle-by-cycle compare of alu_result against the model
  always @(negedge clk) begin
    if (check_en) begin
      tests_run++;
      if (alu_result !== exp_alu) begin
        tests_failed++;
        $display("FAIL cycle_cmp t=%0t inst=%08h got=%08h exp=%08h", $time, inst, alu_result, exp_alu);
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    exp_alu = 32'h0;
  endtask

  // Present one instruction for one cycle and advance the model past the edge
  task automatic step(input logic [31:0] i);
    logic [31:0] res;
    bit          we;
    logic [4:0]  dst;
    @(negedge clk);
    inst = i;
    model_exec(i, res, we, dst);
    @(posedge clk);
    #1;
    exp_alu = res;
    if (we) m_regs[dst] = res;
  endtask

  task automatic check_lit(input string name, input logic [31:0] want);
    tests_run++;
    if (alu_result !== want) begin
      tests_failed++;
      $display("FAIL %s got=%08h exp=%08h", name, alu_result, want);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [5:0]  fn;
    int          kind;
    kind = $urandom_range(0, 9);
    r = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 6'h00};
    if (kind < 5) begin
      case ($urandom_range(0, 15))
        0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
        4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;
        8: fn = 6'h2A;  9: fn = 6'h2B; 10: fn = 6'h00; 11: fn = 6'h02;
        12: fn = 6'h03; 13: fn = 6'h04; 14: fn = 6'h06; default: fn = 6'h07;
      endcase
      r[5:0] = fn;
    end else if (kind < 9) begin
      r[31:26] = 6'($urandom_range(8, 15));
      r[15:0]  = 16'($urandom());
    end else begin
      r = $urandom();
    end
    return r;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    check_en     = 1'b0;
    inst         = 32'h0;
    clear_model();

    // Reset for 5 ns while the clock runs
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #5;
    check_lit("reset_value", 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Directed sequence with hand-computed results
    step(32'h00210820); check_lit("add_after_reset", 32'h0);
    step(32'h20010005); check_lit("addi_5", 32'h5);
    step(32'h00210820); check_lit("dep_10", 32'hA);
    step(32'h00210820); check_lit("dep_20", 32'h14);
    step(32'h00210820); check_lit("dep_40", 32'h28);
    step(32'h3402F0F0); check_lit("ori", 32'h0000F0F0);
    step(32'h3C038000); check_lit("lui", 32'h80000000);
    step(32'h00032103); check_lit("sra", 32'hF8000000);
    step(32'h00032902); check_lit("srl", 32'h08000000);
    step(32'h00003027); check_lit("nor", 32'hFFFFFFFF);
    step(32'h0061382A); check_lit("slt", 32'h1);
    step(32'h0061382B); check_lit("sltu", 32'h0);
    step(32'h2C08FFFF); check_lit("sltiu", 32'h1);
    step(32'h20000007); check_lit("addi_r0", 32'h7);
    step(32'h00004820); check_lit("r0_reads_zero", 32'h0);
    step(32'hFC21FFFF); check_lit("unsupported_op", 32'h0);
    step(32'h00206025); check_lit("r1_unchanged", 32'h28);
    step(32'h3C037FFF); check_lit("lui_7fff", 32'h7FFF0000);
    step(32'h3463FFFF); check_lit("ori_max", 32'h7FFFFFFF);
    step(32'h00635020); check_lit("add_ovf", 32'hFFFFFFFE);
`ifdef MBS_OVF_TRAP_EN
    step(32'h01405825); check_lit("ovf_trapped", 32'h0);
`else
    step(32'h01405825); check_lit("ovf_wraps", 32'hFFFFFFFE);
`endif

    // Randomised instructions checked by the compare process
    for (int n = 0; n < 600; n++) begin
      step(rand_inst());
    end

    // Reset asserted mid-cycle: state clears immediately
    #2 rst_n = 1'b0;
    check_en = 1'b0;
    #1;
    check_lit("mid_reset", 32'h0);
    clear_model();
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;
    step(32'h00226825); check_lit("regs_cleared", 32'h0);

    for (int n = 0; n < 200; n++) begin
      step(rand_inst());
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
